flush_ctrl: RTL and testbench

Parametrised control-hazard and load-use controller for the pipelined RV32 core. It sits beside the MEM stage and takes the resolved next-PC operation, the branch condition, the trap request and the load-use operands. It drives a per-stage flush vector, PC redirect, stalls and an ID/EX bubble. Flush can be held for a configurable number of cycles after a redirect to cover instruction-memory latency. Two saturating performance counters track flush and stall activity.

---
 rtl/flush_ctrl.sv | 157 +++++++++++++++
 tb/tb_flush_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/flush_ctrl.sv
// Control-hazard and load-use controller beside the MEM stage: per-stage flush,
// PC redirect, load-use stalls, optional post-redirect fetch hold and saturating perf counters.
module flush_ctrl #(
    parameter int unsigned NFLUSH   = 3,
    parameter int unsigned IMEM_LAT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        npc_op_i,
    input  logic              zero_i,
    input  logic              trap_i,
    input  logic              mem_busy_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              cnt_clr_i,
    output logic [NFLUSH-1:0] flush_o,
    output logic              redirect_o,
    output logic [1:0]        redirect_sel_o,
    output logic              kill_resolve_o,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              idex_bubble_o,
    output logic              hold_busy_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned HCNT_W = 4;

    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic taken;
    logic evt;
    logic haz;
    logic lu_stall;

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Hazard decode, next-state and combinational outputs
    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        flush_cnt_d    = flush_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        flush_o        = '0;
        redirect_o     = 1'b0;
        redirect_sel_o = SEL_NONE;
        kill_resolve_o = 1'b0;
        pc_stall_o     = 1'b0;
        ifid_stall_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        hold_busy_o    = 1'b0;

        taken = (npc_op_i == NPC_BRANCH && zero_i) || npc_op_i == NPC_JUMP
                || npc_op_i == NPC_JALR;
        evt   = (trap_i || taken) && !mem_busy_i && !rst_i;
        haz   = ex_is_load_i && ex_rd_i != 5'd0
                && ((id_use_rs1_i && id_rs1_i == ex_rd_i)
                    || (id_use_rs2_i && id_rs2_i == ex_rd_i));
        // Redirect and post-redirect hold both make the load-use stall moot
        lu_stall = haz && !evt && state_q == IDLE && !rst_i;

        if (!rst_i) begin
            pc_stall_o    = mem_busy_i || lu_stall;
            ifid_stall_o  = mem_busy_i || lu_stall;
            idex_bubble_o = lu_stall && !mem_busy_i;
        end

        if (state_q == HOLD && !rst_i) begin
            flush_o     = NFLUSH'(1);
            hold_busy_o = 1'b1;
        end

        if (evt) begin
            redirect_o     = 1'b1;
            flush_o        = '1;
            redirect_sel_o = trap_i ? SEL_TRAP : SEL_TARGET;
            kill_resolve_o = trap_i;
        end

        case (state_q)
            IDLE: begin
                if (evt && IMEM_LAT > 0) begin
                    state_d = HOLD;
                    hcnt_d  = HCNT_W'(IMEM_LAT);
                end
            end
            HOLD: begin
                if (evt) begin
                    hcnt_d = HCNT_W'(IMEM_LAT);
                end else if (!mem_busy_i) begin
                    if (hcnt_q == HCNT_W'(1)) begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q - HCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase

        // Saturating counters; a clear drops the same-cycle event
        if (cnt_clr_i) begin
            flush_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (evt && flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (idex_bubble_o && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed scoreboard bench for flush_ctrl (NFLUSH=3, IMEM_LAT=2, CNT_W=2):
// the driver queues each cycle's expected outputs, a negedge monitor pops and compares.
module tb_flush_ctrl;

    typedef struct packed {
        logic       rst;
        logic [2:0] npc;
        logic       zero;
        logic       trap;
        logic       busy;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic [2:0] fl;
        logic       rdr;
        logic [1:0] sel;
        logic       kill;
        logic       stall;
        logic       bub;
        logic       hb;
        logic [1:0] fc;
        logic [1:0] sc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] npc_op;
    logic       zero, trap, mem_busy, ex_is_load;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2, cnt_clr;
    logic [2:0] flush;
    logic       redirect;
    logic [1:0] redirect_sel;
    logic       kill_resolve, pc_stall, ifid_stall, idex_bubble, hold_busy;
    logic [1:0] flush_cnt, stall_cnt;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    flush_ctrl #(.NFLUSH(3), .IMEM_LAT(2), .CNT_W(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .npc_op_i       (npc_op),
        .zero_i         (zero),
        .trap_i         (trap),
        .mem_busy_i     (mem_busy),
        .ex_is_load_i   (ex_is_load),
        .ex_rd_i        (ex_rd),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .cnt_clr_i      (cnt_clr),
        .flush_o        (flush),
        .redirect_o     (redirect),
        .redirect_sel_o (redirect_sel),
        .kill_resolve_o (kill_resolve),
        .pc_stall_o     (pc_stall),
        .ifid_stall_o   (ifid_stall),
        .idex_bubble_o  (idex_bubble),
        .hold_busy_o    (hold_busy),
        .flush_cnt_o    (flush_cnt),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input stim_t s);
        rst        = s.rst;
        npc_op     = s.npc;
        zero       = s.zero;
        trap       = s.trap;
        mem_busy   = s.busy;
        ex_is_load = s.ld;
        ex_rd      = s.rd;
        id_rs1     = s.rs1;
        id_rs2     = s.rs2;
        id_use_rs1 = s.u1;
        id_use_rs2 = s.u2;
        cnt_clr    = s.clr;
    endtask

    task automatic cyc(input string nm, input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic check(input string nm, input string f, input logic [3:0] act,
                         input logic [3:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            check(nm, "flush",        4'(flush),        4'(e.fl));
            check(nm, "redirect",     4'(redirect),     4'(e.rdr));
            check(nm, "redirect_sel", 4'(redirect_sel), 4'(e.sel));
            check(nm, "kill_resolve", 4'(kill_resolve), 4'(e.kill));
            check(nm, "pc_stall",     4'(pc_stall),     4'(e.stall));
            check(nm, "ifid_stall",   4'(ifid_stall),   4'(e.stall));
            check(nm, "idex_bubble",  4'(idex_bubble),  4'(e.bub));
            check(nm, "hold_busy",    4'(hold_busy),    4'(e.hb));
            check(nm, "flush_cnt",    4'(flush_cnt),    4'(e.fc));
            check(nm, "stall_cnt",    4'(stall_cnt),    4'(e.sc));
        end
    end

    initial begin
        stim_t lu;
        stim_t s;
        int    waited;
        lu = '0;
        lu.ld = 1'b1; lu.rd = 5'd5; lu.rs2 = 5'd5; lu.u2 = 1'b1;
        apply('{rst: 1'b1, default: '0});

        cyc("reset",        '{rst: 1'b1, default: '0}, '0);
        cyc("idle",         '0, '0);
        cyc("br_taken",     '{npc: 3'b001, zero: 1'b1, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b01, default: '0});
        cyc("hold1",        '0, '{fl: 3'b001, hb: 1'b1, fc: 2'd1, default: '0});
        cyc("hold2",        '0, '{fl: 3'b001, hb: 1'b1, fc: 2'd1, default: '0});
        cyc("br_not_taken", '{npc: 3'b001, default: '0}, '{fc: 2'd1, default: '0});
        cyc("trap_jalr",    '{npc: 3'b100, trap: 1'b1, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b10, kill: 1'b1, fc: 2'd1, default: '0});
        cyc("jump_in_hold", '{npc: 3'b010, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b01, hb: 1'b1, fc: 2'd2, default: '0});
        cyc("lu_in_hold1",  lu, '{fl: 3'b001, hb: 1'b1, fc: 2'd3, default: '0});
        cyc("lu_in_hold2",  lu, '{fl: 3'b001, hb: 1'b1, fc: 2'd3, default: '0});
        cyc("lu_stall",     lu, '{stall: 1'b1, bub: 1'b1, fc: 2'd3, default: '0});
        cyc("lu_rd0",       '{ld: 1'b1, u2: 1'b1, default: '0}, '{fc: 2'd3, sc: 2'd1, default: '0});
        cyc("lu_vs_jump",   '{npc: 3'b010, ld: 1'b1, rd: 5'd5, rs1: 5'd5, u1: 1'b1, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b01, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("hold_a",       '0, '{fl: 3'b001, hb: 1'b1, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("hold_busy",    '{busy: 1'b1, default: '0},
                            '{fl: 3'b001, hb: 1'b1, stall: 1'b1, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("hold_b",       '0, '{fl: 3'b001, hb: 1'b1, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("hold_done",    '0, '{fc: 2'd3, sc: 2'd1, default: '0});
        cyc("busy_branch",  '{npc: 3'b001, zero: 1'b1, busy: 1'b1, default: '0},
                            '{stall: 1'b1, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("release_br",   '{npc: 3'b001, zero: 1'b1, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b01, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("clr_jump",     '{npc: 3'b010, clr: 1'b1, default: '0},
                            '{fl: 3'b111, rdr: 1'b1, sel: 2'b01, hb: 1'b1, fc: 2'd3, sc: 2'd1, default: '0});
        cyc("after_clr",    '0, '{fl: 3'b001, hb: 1'b1, default: '0});
        cyc("rst_mid_hold", '{rst: 1'b1, npc: 3'b010, default: '0}, '0);
        cyc("post_rst",     '0, '0);
        s = lu;
        s.busy = 1'b1;
        cyc("busy_lu",      s, '{stall: 1'b1, default: '0});
        cyc("lu_again",     lu, '{stall: 1'b1, bub: 1'b1, default: '0});
        cyc("lu_count",     '0, '{sc: 2'd1, default: '0});

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
